// File: rtl/rob_module.sv
// In-order reorder buffer: allocates entries at rename, resolves operands for the
// reservation stations, absorbs FU writebacks and commits the oldest done entry.
module rob_module #(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned GPR_W     = 64,
    parameter int unsigned GPR_IDX_W = 5
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_reg_done,
    input  logic [GPR_IDX_W-1:0] in_reg_dst,
    input  logic                 in_reg_set_nzcv,
    input  logic                 in_reg_src1_valid,
    input  logic                 in_reg_src2_valid,
    input  logic [GPR_W-1:0]     in_reg_src1_value,
    input  logic [GPR_W-1:0]     in_reg_src2_value,
    input  logic [ROB_IDX_W-1:0] in_reg_src1_rob_index,
    input  logic [ROB_IDX_W-1:0] in_reg_src2_rob_index,
    input  logic                 in_fu_done,
    input  logic [ROB_IDX_W-1:0] in_fu_rob_index,
    input  logic [GPR_W-1:0]     in_fu_value,
    input  logic [3:0]           in_fu_nzcv,
    output logic [ROB_IDX_W-1:0] out_reg_next_rob_index,
    output logic                 out_full,
    output logic                 out_rs_done,
    output logic [ROB_IDX_W-1:0] out_rs_dst_rob_index,
    output logic                 out_rs_src1_valid,
    output logic                 out_rs_src2_valid,
    output logic [GPR_W-1:0]     out_rs_src1_value,
    output logic [GPR_W-1:0]     out_rs_src2_value,
    output logic [ROB_IDX_W-1:0] out_rs_src1_rob_index,
    output logic [ROB_IDX_W-1:0] out_rs_src2_rob_index,
    output logic                 out_reg_should_commit,
    output logic [GPR_W-1:0]     out_reg_commit_value,
    output logic [GPR_IDX_W-1:0] out_reg_reg_index,
    output logic [ROB_IDX_W-1:0] out_reg_commit_rob_index,
    output logic                 out_reg_set_nzcv,
    output logic [3:0]           out_reg_nzcv
);

    logic [ROB_DEPTH-1:0] busy_q, done_q, setn_q;
    logic [GPR_IDX_W-1:0] dst_q  [ROB_DEPTH];
    logic [GPR_W-1:0]     val_q  [ROB_DEPTH];
    logic [3:0]           nzcv_q [ROB_DEPTH];
    logic [ROB_IDX_W-1:0] head_q, tail_q;
    logic [ROB_IDX_W:0]   count_q;

    logic         alloc, commit, fu_wb;
    logic [GPR_W:0] src1_res, src2_res;

    // Resolved operand as {valid, value}; regfile wins, then ROB entry, then live writeback.
    function automatic logic [GPR_W:0] resolve(input logic v, input logic [GPR_W-1:0] val,
                                               input logic [ROB_IDX_W-1:0] tag);
        if (v) return {1'b1, val};
        else if (busy_q[tag] && done_q[tag]) return {1'b1, val_q[tag]};
        else if (in_fu_done && (in_fu_rob_index == tag)) return {1'b1, in_fu_value};
        else return '0;
    endfunction

    assign out_reg_next_rob_index = tail_q;
    assign out_full = (count_q == (ROB_IDX_W+1)'(ROB_DEPTH));
    assign alloc    = in_reg_done && !out_full;
    assign commit   = (count_q != '0) && busy_q[head_q] && done_q[head_q];
    assign fu_wb    = in_fu_done && busy_q[in_fu_rob_index];
    assign src1_res = resolve(in_reg_src1_valid, in_reg_src1_value, in_reg_src1_rob_index);
    assign src2_res = resolve(in_reg_src2_valid, in_reg_src2_value, in_reg_src2_rob_index);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            busy_q  <= '0;
            done_q  <= '0;
            setn_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                dst_q[i]  <= '0;
                val_q[i]  <= '0;
                nzcv_q[i] <= '0;
            end
            out_rs_done              <= 1'b0;
            out_rs_dst_rob_index     <= '0;
            out_rs_src1_valid        <= 1'b0;
            out_rs_src2_valid        <= 1'b0;
            out_rs_src1_value        <= '0;
            out_rs_src2_value        <= '0;
            out_rs_src1_rob_index    <= '0;
            out_rs_src2_rob_index    <= '0;
            out_reg_should_commit    <= 1'b0;
            out_reg_commit_value     <= '0;
            out_reg_reg_index        <= '0;
            out_reg_commit_rob_index <= '0;
            out_reg_set_nzcv         <= 1'b0;
            out_reg_nzcv             <= '0;
        end else begin
            if (fu_wb) begin
                done_q[in_fu_rob_index] <= 1'b1;
                val_q[in_fu_rob_index]  <= in_fu_value;
                nzcv_q[in_fu_rob_index] <= in_fu_nzcv;
            end
            out_reg_should_commit <= commit;
            if (commit) begin
                busy_q[head_q]           <= 1'b0;
                head_q                   <= head_q + ROB_IDX_W'(1);
                out_reg_commit_value     <= val_q[head_q];
                out_reg_reg_index        <= dst_q[head_q];
                out_reg_commit_rob_index <= head_q;
                out_reg_set_nzcv         <= setn_q[head_q];
                out_reg_nzcv             <= nzcv_q[head_q];
            end
            out_rs_done <= alloc;
            if (alloc) begin
                busy_q[tail_q]        <= 1'b1;
                done_q[tail_q]        <= 1'b0;
                dst_q[tail_q]         <= in_reg_dst;
                setn_q[tail_q]        <= in_reg_set_nzcv;
                tail_q                <= tail_q + ROB_IDX_W'(1);
                out_rs_dst_rob_index  <= tail_q;
                out_rs_src1_valid     <= src1_res[GPR_W];
                out_rs_src1_value     <= src1_res[GPR_W-1:0];
                out_rs_src1_rob_index <= in_reg_src1_rob_index;
                out_rs_src2_valid     <= src2_res[GPR_W];
                out_rs_src2_value     <= src2_res[GPR_W-1:0];
                out_rs_src2_rob_index <= in_reg_src2_rob_index;
            end
            if (alloc && !commit) count_q <= count_q + (ROB_IDX_W+1)'(1);
            else if (!alloc && commit) count_q <= count_q - (ROB_IDX_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_rob_module.sv
// Self-checking bench for rob_module: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rob_module;
    logic        clk, rst;
    logic        reg_done, reg_setn, s1v, s2v, fu_done;
    logic [4:0]  reg_dst;
    logic [63:0] s1val, s2val, fu_val;
    logic [3:0]  s1tag, s2tag, fu_idx, fu_nzcv;
    logic [3:0]  next_idx, rs_dst, rs_s1tag, rs_s2tag, c_rob, c_nzcv;
    logic        full, rs_done, rs_s1v, rs_s2v, sc, c_setn;
    logic [63:0] rs_s1val, rs_s2val, c_val;
    logic [4:0]  c_reg;

    rob_module dut (
        .in_clk(clk), .in_rst(rst), .in_reg_done(reg_done), .in_reg_dst(reg_dst),
        .in_reg_set_nzcv(reg_setn), .in_reg_src1_valid(s1v), .in_reg_src2_valid(s2v),
        .in_reg_src1_value(s1val), .in_reg_src2_value(s2val),
        .in_reg_src1_rob_index(s1tag), .in_reg_src2_rob_index(s2tag),
        .in_fu_done(fu_done), .in_fu_rob_index(fu_idx), .in_fu_value(fu_val),
        .in_fu_nzcv(fu_nzcv), .out_reg_next_rob_index(next_idx), .out_full(full),
        .out_rs_done(rs_done), .out_rs_dst_rob_index(rs_dst),
        .out_rs_src1_valid(rs_s1v), .out_rs_src2_valid(rs_s2v),
        .out_rs_src1_value(rs_s1val), .out_rs_src2_value(rs_s2val),
        .out_rs_src1_rob_index(rs_s1tag), .out_rs_src2_rob_index(rs_s2tag),
        .out_reg_should_commit(sc), .out_reg_commit_value(c_val), .out_reg_reg_index(c_reg),
        .out_reg_commit_rob_index(c_rob), .out_reg_set_nzcv(c_setn), .out_reg_nzcv(c_nzcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program order lives in a queue of entry indices.
    bit          m_busy[16], m_done[16], m_setn[16];
    logic [4:0]  m_dst[16];
    logic [63:0] m_val[16];
    logic [3:0]  m_nzcv[16];
    int          q[$];
    int          acnt;
    bit          e_rst, e_rs, e_sc, e_s1v, e_s2v, e_setn;
    logic [63:0] e_s1val, e_s2val, e_cval;
    int          e_dst, e_s1tag, e_s2tag, e_crob, e_creg, e_nzcv;

    task automatic resolve(input bit v, input logic [63:0] val, input int tag,
                           output bit ov, output logic [63:0] oval);
        if (v) begin ov = 1; oval = val; end
        else if (m_busy[tag] && m_done[tag]) begin ov = 1; oval = m_val[tag]; end
        else if (fu_done && int'(fu_idx) == tag) begin ov = 1; oval = fu_val; end
        else begin ov = 0; oval = 0; end
    endtask

    always @(posedge clk) begin
        bit alloc, cmt;
        int h, t;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin m_busy[i] = 0; m_done[i] = 0; end
            q.delete();
            acnt = 0; e_rst = 1; e_rs = 0; e_sc = 0;
        end else begin
            e_rst = 0;
            alloc = reg_done && (q.size() != 16);
            cmt   = (q.size() > 0) && m_done[q[0]];
            t     = acnt % 16;
            e_rs  = alloc;
            if (alloc) begin
                e_dst = t; e_s1tag = int'(s1tag); e_s2tag = int'(s2tag);
                resolve(s1v, s1val, int'(s1tag), e_s1v, e_s1val);
                resolve(s2v, s2val, int'(s2tag), e_s2v, e_s2val);
            end
            e_sc = cmt;
            if (cmt) begin
                h = q[0];
                e_cval = m_val[h]; e_creg = int'(m_dst[h]); e_crob = h;
                e_setn = m_setn[h]; e_nzcv = int'(m_nzcv[h]);
            end
            if (fu_done && m_busy[fu_idx]) begin
                m_done[fu_idx] = 1; m_val[fu_idx] = fu_val; m_nzcv[fu_idx] = fu_nzcv;
            end
            if (cmt) begin m_busy[q[0]] = 0; void'(q.pop_front()); end
            if (alloc) begin
                m_busy[t] = 1; m_done[t] = 0; m_dst[t] = reg_dst; m_setn[t] = reg_setn;
                q.push_back(t); acnt++;
            end
        end
        #1;
        chk("full", full, q.size() == 16);
        chk("next_idx", next_idx, acnt % 16);
        chk("rs_done", rs_done, e_rs);
        chk("should_commit", sc, e_sc);
        if (e_rst) begin
            chk("rst_rs", {rs_dst, rs_s1v, rs_s2v, rs_s1tag, rs_s2tag}, 0);
            chk("rst_rs_vals", rs_s1val | rs_s2val, 0);
            chk("rst_commit", {c_reg, c_rob, c_setn, c_nzcv}, 0);
            chk("rst_commit_val", c_val, 0);
        end
        if (e_rs) begin
            chk("rs_dst", rs_dst, e_dst);
            chk("rs_s1v", rs_s1v, e_s1v);
            chk("rs_s1val", rs_s1val, e_s1val);
            chk("rs_s1tag", rs_s1tag, e_s1tag);
            chk("rs_s2v", rs_s2v, e_s2v);
            chk("rs_s2val", rs_s2val, e_s2val);
            chk("rs_s2tag", rs_s2tag, e_s2tag);
        end
        if (e_sc) begin
            chk("c_val", c_val, e_cval);
            chk("c_reg", c_reg, e_creg);
            chk("c_rob", c_rob, e_crob);
            chk("c_setn", c_setn, e_setn);
            chk("c_nzcv", c_nzcv, e_nzcv);
        end
    end

    task automatic idle();
        reg_done = 0; reg_dst = 0; reg_setn = 0; s1v = 1; s2v = 1;
        s1val = 0; s2val = 0; s1tag = 0; s2tag = 0;
        fu_done = 0; fu_idx = 0; fu_val = 0; fu_nzcv = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); rst = 0;
    endtask

    task automatic alloc_one(input logic [4:0] d);
        reg_done = 1; reg_dst = d; step(); reg_done = 0;
    endtask

    initial begin
        rst = 1; idle();
        step(); step(); rst = 0;
        chk("lit_rst_next", next_idx, 0);
        chk("lit_rst_full", full, 0);

        // First allocation and single commit.
        reg_setn = 1; alloc_one(3); reg_setn = 0;
        chk("lit_next1", next_idx, 1);
        chk("lit_rs_done", rs_done, 1);
        chk("lit_rs_dst0", rs_dst, 0);
        fu_done = 1; fu_idx = 0; fu_val = 42; fu_nzcv = 4'b0100; step(); idle();
        chk("lit_no_early_commit", sc, 0);
        step();
        chk("lit_commit", sc, 1);
        chk("lit_commit_val", c_val, 42);
        chk("lit_commit_reg", c_reg, 3);
        chk("lit_commit_rob", c_rob, 0);
        chk("lit_commit_setn", c_setn, 1);
        chk("lit_commit_nzcv", c_nzcv, 4'b0100);
        step();
        chk("lit_commit_pulse", sc, 0);

        // Out-of-order completion commits in order.
        do_reset();
        for (int i = 0; i < 3; i++) alloc_one(5'(10 + i));
        for (int i = 2; i >= 0; i--) begin
            fu_done = 1; fu_idx = 4'(i); fu_val = 64'(100 + i); step();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_ooo_commit", sc, 1);
            chk("lit_ooo_rob", c_rob, i);
        end

        // Operand forwarding.
        do_reset();
        for (int i = 0; i < 7; i++) alloc_one(5'(i));
        fu_done = 1; fu_idx = 5; fu_val = 7; step(); idle();
        s1v = 0; s1tag = 5; s2v = 0; s2tag = 6; alloc_one(1);
        chk("lit_fwd_rob_v", rs_s1v, 1);
        chk("lit_fwd_rob_val", rs_s1val, 7);
        chk("lit_fwd_wait_v", rs_s2v, 0);
        chk("lit_fwd_wait_tag", rs_s2tag, 6);
        chk("lit_fwd_wait_val", rs_s2val, 0);
        s1v = 0; s1tag = 6; fu_done = 1; fu_idx = 6; fu_val = 9; alloc_one(2);
        chk("lit_fwd_fu_v", rs_s1v, 1);
        chk("lit_fwd_fu_val", rs_s1val, 9);

        // Reset mid-operation with a completion in flight.
        idle(); fu_done = 1; fu_idx = 0; fu_val = 55; rst = 1; step(); rst = 0; idle();
        chk("lit_mid_rst_next", next_idx, 0);
        chk("lit_mid_rst_rs", rs_done, 0);
        step();
        chk("lit_mid_rst_commit", sc, 0);
        alloc_one(4);
        chk("lit_mid_rst_alloc", rs_dst, 0);

        // Fill, refuse while full, commit one, wrap to index 0.
        do_reset();
        reg_done = 1;
        for (int i = 0; i < 16; i++) begin reg_dst = 5'(i); step(); end
        chk("lit_full", full, 1);
        chk("lit_full_next", next_idx, 0);
        step();
        chk("lit_full_refused", rs_done, 0);
        fu_done = 1; fu_idx = 0; fu_val = 77; step(); fu_done = 0;
        step();
        chk("lit_wrap_commit", sc, 1);
        chk("lit_wrap_not_full", full, 0);
        chk("lit_wrap_refused", rs_done, 0);
        step();
        chk("lit_wrap_alloc", rs_done, 1);
        chk("lit_wrap_idx", rs_dst, 0);
        chk("lit_wrap_full", full, 1);
        idle();

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int pend[$];
            rst      = ($urandom_range(299) == 0);
            reg_done = $urandom_range(1);
            reg_dst  = 5'($urandom); reg_setn = $urandom_range(1);
            s1v = ($urandom_range(9) < 3); s2v = ($urandom_range(9) < 3);
            s1val = {$urandom, $urandom}; s2val = {$urandom, $urandom};
            s1tag = 4'($urandom); s2tag = 4'($urandom);
            foreach (q[k]) if (!m_done[q[k]]) pend.push_back(q[k]);
            fu_val = {$urandom, $urandom}; fu_nzcv = 4'($urandom);
            if (pend.size() > 0 && $urandom_range(9) < 6) begin
                fu_done = 1; fu_idx = 4'(pend[$urandom_range(pend.size() - 1)]);
            end else begin
                fu_done = ($urandom_range(19) == 0); fu_idx = 4'($urandom);
            end
            step();
        end
        idle(); rst = 0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
